// File: rtl/idu_stage.sv
// RV64I(M) decode stage: in-order instruction queue feeding a registered decode bundle.
// Optional M-extension decode is enabled by defining IDU_RV64M_EN.
module idu_stage #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rdc,
  output logic [4:0]      out_rs1c,
  output logic [4:0]      out_rs2c,
  output logic [63:0]     out_imm,
  output logic [4:0]      out_alu_op,
  output logic [1:0]      out_alub_sel,
  output logic [2:0]      out_rd_sel,
  output logic            out_rf_w,
  output logic            out_dm_r,
  output logic            out_dm_w,
  output logic [1:0]      out_mem_size,
  output logic            out_mem_uns,
  output logic [2:0]      out_br_op,
  output logic [1:0]      out_jump,
  output logic            out_illegal
);
  localparam int AW = $clog2(DEPTH);

  // Handshakes: a beat moves when valid & ready are both 1 at a rising edge;
  // valid never waits on ready, and in_ready depends only on queue occupancy.
  logic [31:0]     r_q_instr [DEPTH];
  logic [PC_W-1:0] r_q_pc    [DEPTH];
  logic [AW:0]     r_wptr, r_rptr;
  logic            r_out_valid;

  logic w_empty, w_full, w_load, w_accept, w_pop, w_bypass, w_push, w_fill;
  logic [31:0]     w_src_instr;
  logic [PC_W-1:0] w_src_pc;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign in_ready = !w_full;
  assign w_load   = !r_out_valid || out_ready;
  assign w_accept = in_valid && !w_full && !flush;
  assign w_pop    = w_load && !w_empty;
  assign w_bypass = w_load && w_empty && w_accept;
  assign w_push   = w_accept && !w_bypass;
  assign w_fill   = w_pop || w_bypass;

  assign w_src_instr = w_empty ? in_instr : r_q_instr[r_rptr[AW-1:0]];
  assign w_src_pc    = w_empty ? in_pc    : r_q_pc[r_rptr[AW-1:0]];

  // Decode of the selected source instruction
  logic [6:0] w_op, w_f7;
  logic [2:0] w_f3;
  logic [63:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
  assign w_op = w_src_instr[6:0];
  assign w_f3 = w_src_instr[14:12];
  assign w_f7 = w_src_instr[31:25];
  assign w_imm_i  = {{52{w_src_instr[31]}}, w_src_instr[31:20]};
  assign w_imm_s  = {{52{w_src_instr[31]}}, w_src_instr[31:25], w_src_instr[11:7]};
  assign w_imm_b  = {{51{w_src_instr[31]}}, w_src_instr[31], w_src_instr[7],
                     w_src_instr[30:25], w_src_instr[11:8], 1'b0};
  assign w_imm_u  = {{32{w_src_instr[31]}}, w_src_instr[31:12], 12'b0};
  assign w_imm_j  = {{43{w_src_instr[31]}}, w_src_instr[31], w_src_instr[19:12],
                     w_src_instr[20], w_src_instr[30:21], 1'b0};
  assign w_imm_sh = {58'b0, w_src_instr[25:20]};

  logic [63:0] w_imm;
  logic [4:0]  w_alu;
  logic [1:0]  w_alub, w_size, w_jump;
  logic [2:0]  w_rd_sel, w_br;
  logic        w_legal, w_rf_w, w_dm_r, w_dm_w, w_uns, w_nowb;

  always_comb begin
    w_imm = '0; w_alu = '0; w_alub = '0; w_rd_sel = '0; w_size = '0; w_uns = 1'b0;
    w_dm_r = 1'b0; w_dm_w = 1'b0; w_br = '0; w_jump = '0; w_legal = 1'b0; w_nowb = 1'b0;
    w_rf_w = 1'b0;
    case (w_op)
      7'b0110011: begin
        if (w_f7 == 7'b0000000) begin
          w_legal = 1'b1;
          case (w_f3)
            3'd0: w_alu = 5'd0;  3'd1: w_alu = 5'd7;  3'd2: w_alu = 5'd5;  3'd3: w_alu = 5'd6;
            3'd4: w_alu = 5'd4;  3'd5: w_alu = 5'd8;  3'd6: w_alu = 5'd3;  default: w_alu = 5'd2;
          endcase
        end else if (w_f7 == 7'b0100000 && (w_f3 == 3'd0 || w_f3 == 3'd5)) begin
          w_legal = 1'b1;
          w_alu   = (w_f3 == 3'd0) ? 5'd1 : 5'd9;
        end
`ifdef IDU_RV64M_EN
        else if (w_f7 == 7'b0000001) begin
          w_legal = 1'b1;
          w_alu   = 5'd15 + {2'b00, w_f3};
        end
`endif
      end
      7'b0111011: begin
        if (w_f7 == 7'b0000000 && (w_f3 == 3'd0 || w_f3 == 3'd1 || w_f3 == 3'd5)) begin
          w_legal = 1'b1;
          w_alu   = (w_f3 == 3'd0) ? 5'd10 : ((w_f3 == 3'd1) ? 5'd12 : 5'd13);
        end else if (w_f7 == 7'b0100000 && (w_f3 == 3'd0 || w_f3 == 3'd5)) begin
          w_legal = 1'b1;
          w_alu   = (w_f3 == 3'd0) ? 5'd11 : 5'd14;
        end
`ifdef IDU_RV64M_EN
        else if (w_f7 == 7'b0000001 && (w_f3 == 3'd0 || w_f3[2])) begin
          w_legal = 1'b1;
          w_alu   = (w_f3 == 3'd0) ? 5'd23 : (5'd20 + {2'b00, w_f3});
        end
`endif
      end
      7'b0010011: begin
        w_alub = 2'd1;
        w_imm  = w_imm_i;
        case (w_f3)
          3'd0: begin w_legal = 1'b1; w_alu = 5'd0; end
          3'd2: begin w_legal = 1'b1; w_alu = 5'd5; end
          3'd3: begin w_legal = 1'b1; w_alu = 5'd6; end
          3'd4: begin w_legal = 1'b1; w_alu = 5'd4; end
          3'd6: begin w_legal = 1'b1; w_alu = 5'd3; end
          3'd7: begin w_legal = 1'b1; w_alu = 5'd2; end
          3'd1: begin
            w_legal = (w_src_instr[31:26] == 6'b000000);
            w_alu = 5'd7; w_alub = 2'd2; w_imm = w_imm_sh;
          end
          default: begin
            w_legal = (w_src_instr[31:26] == 6'b000000) || (w_src_instr[31:26] == 6'b010000);
            w_alu = w_src_instr[30] ? 5'd9 : 5'd8; w_alub = 2'd2; w_imm = w_imm_sh;
          end
        endcase
      end
      7'b0011011: begin
        if (w_f3 == 3'd0) begin
          w_legal = 1'b1; w_alu = 5'd10; w_alub = 2'd1; w_imm = w_imm_i;
        end else begin
          w_legal = (w_f3 == 3'd1 && w_f7 == 7'b0000000) ||
                    (w_f3 == 3'd5 && (w_f7 == 7'b0000000 || w_f7 == 7'b0100000));
          w_alu   = (w_f3 == 3'd1) ? 5'd12 : (w_src_instr[30] ? 5'd14 : 5'd13);
          w_alub  = 2'd2; w_imm = w_imm_sh;
        end
      end
      7'b0000011: begin
        w_legal = (w_f3 != 3'd7);
        w_dm_r = 1'b1; w_rd_sel = 3'd4; w_alub = 2'd1; w_imm = w_imm_i;
        w_size = w_f3[1:0]; w_uns = w_f3[2];
      end
      7'b0100011: begin
        w_legal = !w_f3[2];
        w_dm_w = 1'b1; w_nowb = 1'b1; w_alub = 2'd1; w_imm = w_imm_s; w_size = w_f3[1:0];
      end
      7'b1100011: begin
        w_legal = (w_f3 != 3'd2) && (w_f3 != 3'd3);
        w_nowb  = 1'b1; w_imm = w_imm_b;
        w_br    = w_f3[2] ? (w_f3 - 3'd1) : (w_f3 + 3'd1);
      end
      7'b1101111: begin w_legal = 1'b1; w_jump = 2'd1; w_rd_sel = 3'd1; w_imm = w_imm_j; end
      7'b1100111: begin
        w_legal = (w_f3 == 3'd0);
        w_jump = 2'd2; w_rd_sel = 3'd1; w_alub = 2'd1; w_imm = w_imm_i;
      end
      7'b0110111: begin w_legal = 1'b1; w_rd_sel = 3'd2; w_imm = w_imm_u; end
      7'b0010111: begin w_legal = 1'b1; w_rd_sel = 3'd3; w_imm = w_imm_u; end
      default: w_legal = 1'b0;
    endcase
    w_rf_w = w_legal && !w_nowb;
    if (!w_legal) begin
      w_dm_r = 1'b0; w_dm_w = 1'b0; w_br = '0; w_jump = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wptr[AW-1:0]] <= in_instr;
      r_q_pc[r_wptr[AW-1:0]]    <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0; r_rptr <= '0; r_out_valid <= 1'b0;
      out_pc <= '0; out_rdc <= '0; out_rs1c <= '0; out_rs2c <= '0; out_imm <= '0;
      out_alu_op <= '0; out_alub_sel <= '0; out_rd_sel <= '0; out_rf_w <= 1'b0;
      out_dm_r <= 1'b0; out_dm_w <= 1'b0; out_mem_size <= '0; out_mem_uns <= 1'b0;
      out_br_op <= '0; out_jump <= '0; out_illegal <= 1'b0;
    end else if (flush) begin
      r_wptr <= '0; r_rptr <= '0; r_out_valid <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_load) r_out_valid <= w_fill;
      if (w_fill) begin
        out_pc <= w_src_pc; out_rdc <= w_src_instr[11:7]; out_rs1c <= w_src_instr[19:15];
        out_rs2c <= w_src_instr[24:20]; out_imm <= w_imm; out_alu_op <= w_alu;
        out_alub_sel <= w_alub; out_rd_sel <= w_rd_sel; out_rf_w <= w_rf_w;
        out_dm_r <= w_dm_r; out_dm_w <= w_dm_w; out_mem_size <= w_size; out_mem_uns <= w_uns;
        out_br_op <= w_br; out_jump <= w_jump; out_illegal <= !w_legal;
      end
    end
  end

  assign out_valid = r_out_valid;
endmodule

// File: tb/tb_idu_stage.sv
// Directed bench for idu_stage: queued expected bundles checked by an output monitor.
module tb_idu_stage;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [4:0]  out_rdc, out_rs1c, out_rs2c, out_alu_op;
  logic [1:0]  out_alub_sel, out_mem_size, out_jump;
  logic [2:0]  out_rd_sel, out_br_op;
  logic        out_rf_w, out_dm_r, out_dm_w, out_mem_uns, out_illegal;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rdc, rs1c, rs2c;
    logic [63:0] imm;
    logic [4:0]  alu;
    logic [1:0]  alub;
    logic [2:0]  rd_sel;
    logic        rf_w, dm_r, dm_w;
    logic [1:0]  size;
    logic        uns;
    logic [2:0]  br;
    logic [1:0]  jump;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  idu_stage #(.DEPTH(4), .PC_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rdc(out_rdc), .out_rs1c(out_rs1c),
    .out_rs2c(out_rs2c), .out_imm(out_imm), .out_alu_op(out_alu_op),
    .out_alub_sel(out_alub_sel), .out_rd_sel(out_rd_sel), .out_rf_w(out_rf_w),
    .out_dm_r(out_dm_r), .out_dm_w(out_dm_w), .out_mem_size(out_mem_size),
    .out_mem_uns(out_mem_uns), .out_br_op(out_br_op), .out_jump(out_jump),
    .out_illegal(out_illegal)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [4:0] rdc, input logic [4:0] rs1c,
                              input logic [4:0] rs2c, input logic [63:0] imm,
                              input logic [4:0] alu, input logic [1:0] alub,
                              input logic [2:0] rd_sel, input logic rf_w, input logic dm_r,
                              input logic dm_w, input logic [1:0] size, input logic uns,
                              input logic [2:0] br, input logic [1:0] jump);
    exp_t e;
    e = '0;
    e.rdc = rdc; e.rs1c = rs1c; e.rs2c = rs2c; e.imm = imm; e.alu = alu; e.alub = alub;
    e.rd_sel = rd_sel; e.rf_w = rf_w; e.dm_r = dm_r; e.dm_w = dm_w; e.size = size;
    e.uns = uns; e.br = br; e.jump = jump;
    return e;
  endfunction

  function automatic exp_t mk_ill();
    exp_t e;
    e = '0;
    e.illegal = 1'b1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic push_beat(input logic [31:0] instr, input logic [63:0] pc, input exp_t e);
    int  n;
    bit  done;
    n = 0; done = 1'b0;
    e.pc = pc;
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end else if (++n > 50) begin
        total++; bad++;
        $display("FAIL push_timeout: pc %0h never accepted", pc);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d bundles outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // scoreboard monitor
  exp_t m_act, m_exp;
  bit   m_ok;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      m_act = {out_pc, out_rdc, out_rs1c, out_rs2c, out_imm, out_alu_op, out_alub_sel,
               out_rd_sel, out_rf_w, out_dm_r, out_dm_w, out_mem_size, out_mem_uns,
               out_br_op, out_jump, out_illegal};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_bundle: got pc %0h, expected no output", out_pc);
      end else begin
        m_exp = exp_q.pop_front();
        if (m_exp.illegal)
          m_ok = (m_act.pc == m_exp.pc) && m_act.illegal && !m_act.rf_w && !m_act.dm_r &&
                 !m_act.dm_w && (m_act.br == 3'd0) && (m_act.jump == 2'd0);
        else
          m_ok = (m_act === m_exp);
        if (!m_ok) begin
          bad++;
          $display("FAIL bundle pc %0h: got %h expected %h", m_exp.pc, m_act, m_exp);
        end
      end
    end
  end

  initial begin
    logic [31:0] ins;
    int acc;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_imm", out_imm, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_rf_w", {63'b0, out_rf_w}, 64'd0);
    chk("rst_out_alu_op", {59'b0, out_alu_op}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // main decode vectors, consumer always ready
    out_ready = 1'b1;
    push_beat(32'h00500093, 64'h80000000, mk(1, 0, 5, 64'd5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    chk("latency_out_valid", {63'b0, out_valid}, 64'd1);
    push_beat(32'h0020B423, 64'h80000004, mk(8, 1, 2, 64'd8, 0, 1, 0, 0, 0, 1, 3, 0, 0, 0));
    push_beat(32'hFE000EE3, 64'h80000008,
              mk(29, 0, 0, 64'hFFFFFFFFFFFFFFFC, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    push_beat(32'h002081B3, 64'h8000000C, mk(3, 1, 2, 64'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    push_beat(32'h402081B3, 64'h80000010, mk(3, 1, 2, 64'd0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    push_beat(32'h43F35293, 64'h80000014, mk(5, 6, 31, 64'd63, 9, 2, 0, 1, 0, 0, 0, 0, 0, 0));
    push_beat(32'hFFE45383, 64'h80000018,
              mk(7, 8, 30, 64'hFFFFFFFFFFFFFFFE, 0, 1, 4, 1, 1, 0, 1, 1, 0, 0));
    push_beat(32'h12345537, 64'h8000001C,
              mk(10, 8, 3, 64'h12345000, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0));
    push_beat(32'h010000EF, 64'h80000020, mk(1, 0, 16, 64'd16, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    push_beat(32'h00008067, 64'h80000024, mk(0, 1, 0, 64'd0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 2));
    push_beat(32'h4020D1BB, 64'h80000028, mk(3, 1, 2, 64'd0, 14, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    push_beat(32'hFFFFF297, 64'h8000002C,
              mk(5, 31, 31, 64'hFFFFFFFFFFFFF000, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0));
`ifdef IDU_RV64M_EN
    push_beat(32'h022081B3, 64'h80000030, mk(3, 1, 2, 64'd0, 15, 0, 0, 1, 0, 0, 0, 0, 0, 0));
`else
    push_beat(32'h022081B3, 64'h80000030, mk_ill());
`endif
    push_beat(32'hFFFFFFFF, 64'h80000034, mk_ill());
    wait_drain("drain_main");

    // backpressure: six single-shot offers against a stalled consumer
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      ins = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
      in_valid = 1'b1; in_instr = ins; in_pc = 64'h1000 + 64'(4 * i);
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(mk(5'(i + 1), 0, 5'(i), 64'(i), 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        exp_q[exp_q.size() - 1].pc = 64'h1000 + 64'(4 * i);
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd5);
    chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
    out_ready = 1'b1;
    wait_drain("drain_bp");

    // flush with three buffered and a concurrent beat
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_beat(32'h00000013, 64'h2000 + 64'(4 * i), mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h3000; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("flush_stays_empty", {63'b0, out_valid}, 64'd0);
    push_beat(32'h00700113, 64'h4000, mk(2, 0, 7, 64'd7, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    wait_drain("drain_flush");

    // asynchronous reset in the middle of traffic
    out_ready = 1'b0;
    push_beat(32'h00500093, 64'h5000, mk(1, 0, 5, 64'd5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    push_beat(32'h00600093, 64'h5004, mk(1, 0, 6, 64'd6, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("async_rst_in_ready", {63'b0, in_ready}, 64'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    push_beat(32'h00800093, 64'h6000, mk(1, 0, 8, 64'd8, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    wait_drain("drain_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
